regfile_debug_port: RTL and testbench

//  Debug-side access port to the RV32 integer register file (x0-x31).

---
 rtl/regfile_debug_port.sv | 201 ++++++++++++++++++++
 tb/tb_regfile_debug_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_port.sv
// -----------------------------------------------------------------------------
// regfile_debug_port
//   Debug-side access port to the RV32 integer register file (x0-x31).
//   Takes one read/write command at a time over a valid/ready handshake.
//   For each command it:
//     1. halts the core,
//     2. reads or writes one GPR through the register file ports,
//     3. returns a response on a second valid/ready channel.
//   Only one command is in flight: no new command is accepted until the
//   response has been consumed.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   dbg_valid_i / dbg_ready_o   command handshake (ready only while idle)
//   dbg_write_i                 1 = write GPR, 0 = read GPR
//   dbg_addr_i                  GPR index
//   dbg_wdata_i                 write data
//   dbg_rvalid_o / dbg_rready_i response handshake
//   dbg_rdata_o                 read data (0 for writes and errors)
//   dbg_err_o                   halt timeout, no access performed
//   halt_req_o / halted_i       core halt request / acknowledge
//   rf_raddr_o / rf_rdata_i     register file async read port
//   rf_we_o                     register file write enable
//   rf_waddr_o / rf_wdata_o     register file write address / data
// -----------------------------------------------------------------------------
module regfile_debug_port #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dbg_valid_i,
  output logic                  dbg_ready_o,
  input  logic                  dbg_write_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_rvalid_o,
  input  logic                  dbg_rready_i,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  dbg_err_o,
  output logic                  halt_req_o,
  input  logic                  halted_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o
);

  localparam int CNT_WIDTH = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(HALT_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HALT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_nxt_s;
  logic                  cmd_write_r, cmd_write_nxt_s;
  logic [ADDR_WIDTH-1:0] cmd_addr_r, cmd_addr_nxt_s;
  logic [DATA_WIDTH-1:0] cmd_wdata_r, cmd_wdata_nxt_s;
  logic                  rvalid_r, rvalid_nxt_s;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_nxt_s;
  logic                  err_r, err_nxt_s;
  logic                  ready_r, ready_nxt_s;
  logic                  halt_req_r, halt_req_nxt_s;
  logic                  rf_we_r, rf_we_nxt_s;

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    cmd_write_nxt_s = cmd_write_r;
    cmd_addr_nxt_s  = cmd_addr_r;
    cmd_wdata_nxt_s = cmd_wdata_r;
    rvalid_nxt_s    = 1'b0;
    rdata_nxt_s     = rdata_r;
    err_nxt_s       = err_r;

    case (state_r)
      ST_IDLE: begin
        if (dbg_valid_i && ready_r) begin
          cmd_write_nxt_s = dbg_write_i;
          cmd_addr_nxt_s  = dbg_addr_i;
          cmd_wdata_nxt_s = dbg_wdata_i;
          cnt_nxt_s       = CNT_ZERO;
          rdata_nxt_s     = DATA_ZERO;
          err_nxt_s       = 1'b0;
          state_nxt_s     = ST_HALT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_HALT: begin
        // halted_i is checked first so it wins over a same-cycle expiry.
        if (halted_i) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_ACCESS;
        end else if (cnt_r == CNT_LAST) begin
          rdata_nxt_s = DATA_ZERO;
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end

      ST_ACCESS: begin
        // The RF read is asynchronous; raddr has been stable since the
        // command was latched, so rf_rdata_i is valid here.
        if (cmd_write_r) begin
          rdata_nxt_s = DATA_ZERO;
        end else begin
          rdata_nxt_s = rf_rdata_i;
        end
        err_nxt_s   = 1'b0;
        state_nxt_s = ST_RESP;
      end

      ST_RESP: begin
        // rvalid rises one cycle after entering RESP; the response
        // registers are loaded by then and stay frozen until consumed.
        if (rvalid_r && dbg_rready_i) begin
          rvalid_nxt_s = 1'b0;
          state_nxt_s  = ST_IDLE;
        end else begin
          rvalid_nxt_s = 1'b1;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    ready_nxt_s    = (state_nxt_s == ST_IDLE);
    halt_req_nxt_s = (state_nxt_s == ST_HALT) || (state_nxt_s == ST_ACCESS) ||
                     ((state_nxt_s == ST_RESP) && !err_nxt_s);
    // A write to x0 is dropped: the enable never rises for index 0.
    rf_we_nxt_s    = (state_nxt_s == ST_ACCESS) && cmd_write_nxt_s &&
                     (cmd_addr_nxt_s != ADDR_ZERO);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= CNT_ZERO;
      cmd_write_r <= 1'b0;
      cmd_addr_r  <= ADDR_ZERO;
      cmd_wdata_r <= DATA_ZERO;
      rvalid_r    <= 1'b0;
      rdata_r     <= DATA_ZERO;
      err_r       <= 1'b0;
      ready_r     <= 1'b1;
      halt_req_r  <= 1'b0;
      rf_we_r     <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      cmd_write_r <= cmd_write_nxt_s;
      cmd_addr_r  <= cmd_addr_nxt_s;
      cmd_wdata_r <= cmd_wdata_nxt_s;
      rvalid_r    <= rvalid_nxt_s;
      rdata_r     <= rdata_nxt_s;
      err_r       <= err_nxt_s;
      ready_r     <= ready_nxt_s;
      halt_req_r  <= halt_req_nxt_s;
      rf_we_r     <= rf_we_nxt_s;
    end
  end

  assign dbg_ready_o  = ready_r;
  assign dbg_rvalid_o = rvalid_r;
  assign dbg_rdata_o  = rdata_r;
  assign dbg_err_o    = err_r;
  assign halt_req_o   = halt_req_r;
  assign rf_we_o      = rf_we_r;
  // RF address/data come straight from the latched command registers, so
  // they are stable for the whole transaction, not only during ACCESS.
  assign rf_raddr_o   = cmd_addr_r;
  assign rf_waddr_o   = cmd_addr_r;
  assign rf_wdata_o   = cmd_wdata_r;

endmodule

// File: tb/tb_regfile_debug_port.sv
module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_valid_i;
  logic        dbg_ready_o;
  logic        dbg_write_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_rvalid_o;
  logic        dbg_rready_i;
  logic [31:0] dbg_rdata_o;
  logic        dbg_err_o;
  logic        halt_req_o;
  logic        halted_i;
  logic [4:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int checks = 0;
  int failures = 0;

  // Register file model: stores writes literally, async read.
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  int          we_cnt = 0;
  logic [4:0]  last_waddr = 5'd0;
  logic [31:0] last_wdata = 32'h0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we_o === 1'b1) begin
      rf_mem[rf_waddr_o] <= rf_wdata_o;
      we_cnt             <= we_cnt + 1;
      last_waddr         <= rf_waddr_o;
      last_wdata         <= rf_wdata_o;
    end
  end

  assign rf_rdata_i = rf_mem[rf_raddr_o];

  regfile_debug_port #(
    .ADDR_WIDTH  (5),
    .DATA_WIDTH  (32),
    .HALT_TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dbg_valid_i (dbg_valid_i),
    .dbg_ready_o (dbg_ready_o),
    .dbg_write_i (dbg_write_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .dbg_rvalid_o(dbg_rvalid_o),
    .dbg_rready_i(dbg_rready_i),
    .dbg_rdata_o (dbg_rdata_o),
    .dbg_err_o   (dbg_err_o),
    .halt_req_o  (halt_req_o),
    .halted_i    (halted_i),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o)
  );

  // Issue one command, wait (bounded) for rvalid, optionally consume it.
  // cycles = rising edges from the handshake edge to the first rvalid sample.
  task automatic run_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                         input bit consume, output logic [31:0] rdata, output logic err,
                         output logic hreq, output int cycles, output logic ready_hs);
    @(negedge clk);
    dbg_write_i = wr;
    dbg_addr_i  = addr;
    dbg_wdata_i = wdata;
    dbg_valid_i = 1'b1;
    ready_hs    = dbg_ready_o;
    @(posedge clk);
    #1 dbg_valid_i = 1'b0;
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (dbg_rvalid_o === 1'b1) break;
    end
    rdata = dbg_rdata_o;
    err   = dbg_err_o;
    hreq  = halt_req_o;
    if (consume) begin
      dbg_rready_i = 1'b1;
      @(posedge clk);
      #1 dbg_rready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dbg_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", dbg_ready_o); end
    checks++; if (dbg_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b expected 0", dbg_rvalid_o); end
    checks++; if (halt_req_o !== 1'b0) begin failures++; $display("FAIL reset_halt_req: got %b expected 0", halt_req_o); end
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL reset_rf_we: got %b expected 0", rf_we_o); end
    checks++; if (dbg_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", dbg_rdata_o); end
    checks++; if (dbg_err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", dbg_err_o); end
    checks++; if (rf_waddr_o !== 5'd0 || rf_raddr_o !== 5'd0) begin failures++; $display("FAIL reset_rf_addr: got %h/%h expected 0/0", rf_waddr_o, rf_raddr_o); end
    checks++; if (rf_wdata_o !== 32'h0) begin failures++; $display("FAIL reset_rf_wdata: got %h expected 0", rf_wdata_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    logic [31:0] rd; logic er, hq, rdy; int cyc, we0;
    halted_i = 1'b1;
    we0 = we_cnt;
    run_cmd(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, rd, er, hq, cyc, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL write_ready: got %b expected 1", rdy); end
    checks++; if (cyc != 3) begin failures++; $display("FAIL write_latency: got %0d expected 3", cyc); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL write_err: got %b expected 0", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL write_rdata: got %h expected 0", rd); end
    checks++; if (hq !== 1'b1) begin failures++; $display("FAIL write_halt_in_resp: got %b expected 1", hq); end
    checks++; if (we_cnt - we0 != 1) begin failures++; $display("FAIL write_we_pulses: got %0d expected 1", we_cnt - we0); end
    checks++; if (last_waddr !== 5'd5) begin failures++; $display("FAIL write_waddr: got %0d expected 5", last_waddr); end
    checks++; if (last_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL write_wdata: got %h expected deadbeef", last_wdata); end
    @(negedge clk);
    checks++; if (dbg_ready_o !== 1'b1 || halt_req_o !== 1'b0) begin failures++; $display("FAIL write_back_idle: got ready=%b halt=%b expected 1/0", dbg_ready_o, halt_req_o); end
  endtask

  task automatic test_read();
    logic [31:0] rd; logic er, hq, rdy; int cyc, we0;
    we0 = we_cnt;
    run_cmd(1'b0, 5'd5, 32'h0, 1'b1, rd, er, hq, cyc, rdy);
    checks++; if (cyc != 3) begin failures++; $display("FAIL read_latency: got %0d expected 3", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL read_rdata: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL read_err: got %b expected 0", er); end
    checks++; if (we_cnt != we0) begin failures++; $display("FAIL read_no_write: got %0d pulses expected 0", we_cnt - we0); end
  endtask

  task automatic test_x0();
    logic [31:0] rd; logic er, hq, rdy; int cyc, we0;
    we0 = we_cnt;
    run_cmd(1'b1, 5'd0, 32'h12345678, 1'b1, rd, er, hq, cyc, rdy);
    checks++; if (we_cnt != we0) begin failures++; $display("FAIL x0_no_we: got %0d pulses expected 0", we_cnt - we0); end
    checks++; if (er !== 1'b0 || cyc != 3) begin failures++; $display("FAIL x0_write_resp: got err=%b cyc=%0d expected 0/3", er, cyc); end
    run_cmd(1'b0, 5'd0, 32'h0, 1'b1, rd, er, hq, cyc, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL x0_read: got %h expected 0", rd); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er, hq, rdy; int cyc, we0;
    halted_i = 1'b0;
    we0 = we_cnt;
    run_cmd(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, rd, er, hq, cyc, rdy);
    checks++; if (cyc != 5) begin failures++; $display("FAIL timeout_latency: got %0d expected 5", cyc); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL timeout_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL timeout_rdata: got %h expected 0", rd); end
    checks++; if (hq !== 1'b0) begin failures++; $display("FAIL timeout_halt_in_resp: got %b expected 0", hq); end
    checks++; if (we_cnt != we0) begin failures++; $display("FAIL timeout_no_we: got %0d pulses expected 0", we_cnt - we0); end
    halted_i = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er, hq, rdy; int cyc, we0;
    we0 = we_cnt;
    run_cmd(1'b0, 5'd5, 32'h0, 1'b0, rd, er, hq, cyc, rdy);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL bp_first: got %h/%b expected deadbeef/0", rd, er); end
    for (int i = 0; i < 10; i++) begin
      dbg_valid_i = 1'b1; dbg_write_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h99999999;
      @(negedge clk);
      checks++;
      if (dbg_rvalid_o !== 1'b1 || dbg_rdata_o !== 32'hDEADBEEF || dbg_err_o !== 1'b0 || dbg_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got rvalid=%b rdata=%h err=%b ready=%b expected 1/deadbeef/0/0",
                 i, dbg_rvalid_o, dbg_rdata_o, dbg_err_o, dbg_ready_o);
      end
    end
    dbg_valid_i  = 1'b0;
    dbg_rready_i = 1'b1;
    @(posedge clk);
    #1 dbg_rready_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dbg_ready_o !== 1'b1 || dbg_rvalid_o !== 1'b0) begin failures++; $display("FAIL bp_release: got ready=%b rvalid=%b expected 1/0", dbg_ready_o, dbg_rvalid_o); end
    checks++; if (we_cnt != we0) begin failures++; $display("FAIL bp_no_second_cmd: got %0d pulses expected 0", we_cnt - we0); end
    checks++; if (rf_mem[9] !== 32'h0) begin failures++; $display("FAIL bp_x9_untouched: got %h expected 0", rf_mem[9]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, hq, rdy; int cyc;
    run_cmd(1'b1, 5'd31, 32'h80000001, 1'b1, rd, er, hq, cyc, rdy);
    run_cmd(1'b1, 5'd10, 32'h0A0A0A0A, 1'b1, rd, er, hq, cyc, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", rdy); end
    run_cmd(1'b0, 5'd31, 32'h0, 1'b1, rd, er, hq, cyc, rdy);
    checks++; if (rd !== 32'h80000001) begin failures++; $display("FAIL b2b_read_x31: got %h expected 80000001", rd); end
    run_cmd(1'b0, 5'd10, 32'h0, 1'b1, rd, er, hq, cyc, rdy);
    checks++; if (rd !== 32'h0A0A0A0A) begin failures++; $display("FAIL b2b_read_x10: got %h expected 0a0a0a0a", rd); end
  endtask

  task automatic test_reset_mid();
    int we0;
    halted_i = 1'b1;
    we0 = we_cnt;
    @(negedge clk);
    dbg_valid_i = 1'b1; dbg_write_i = 1'b1; dbg_addr_i = 5'd3; dbg_wdata_i = 32'h55AA55AA;
    @(posedge clk);
    #1 dbg_valid_i = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3) begin failures++; $display("FAIL rmid_in_access: got we=%b waddr=%0d expected 1/3", rf_we_o, rf_waddr_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL rmid_we_drop: got %b expected 0", rf_we_o); end
    checks++; if (halt_req_o !== 1'b0) begin failures++; $display("FAIL rmid_halt_drop: got %b expected 0", halt_req_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dbg_ready_o !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b expected 1", dbg_ready_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (dbg_rvalid_o !== 1'b0 || halt_req_o !== 1'b0) begin
        failures++;
        $display("FAIL rmid_no_resp[%0d]: got rvalid=%b halt=%b expected 0/0", i, dbg_rvalid_o, halt_req_o);
      end
    end
    checks++; if (we_cnt != we0 || rf_mem[3] !== 32'h0) begin failures++; $display("FAIL rmid_no_write: got pulses=%0d x3=%h expected 0/0", we_cnt - we0, rf_mem[3]); end
  endtask

  initial begin
    rst_n        = 1'b0;
    dbg_valid_i  = 1'b0;
    dbg_write_i  = 1'b0;
    dbg_addr_i   = 5'd0;
    dbg_wdata_i  = 32'h0;
    dbg_rready_i = 1'b0;
    halted_i     = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_x0();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
